hazard_sequencer: RTL and testbench
===================================

Name: hazard_sequencer

Overview:
- Pipeline sequencing controller that sits beside the Control_Unit in the ID stage.
- Generates PC/IF-ID write enables, ID/EX bubble insertion and IF/ID flush for load-use hazards, taken branches and jumps.
- Sequences the multi-cycle MADDU multiplier: start pulse, busy window, HI/LO writeback pulse.

Parameters:
- MUL_LATENCY, 4, cycles the multiplier occupies after Mul_Start (legal range 1..15).
- CNT_W, 4, width of the internal multiplier countdown counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ID_Opcode  input  6  opcode of the instruction in ID.
- ID_Rs  input  5  rs field of the instruction in ID.
- ID_Rt  input  5  rt field of the instruction in ID.
- EX_MemRead  input  1  instruction in EX is LW.
- EX_Rt  input  5  destination register of the instruction in EX.
- EX_BranchTaken  input  1  BEQ resolved taken in EX.
- PCWrite  output  1  PC update enable.
- IF_ID_Write  output  1  IF/ID register enable.
- IF_ID_Flush  output  1  clear IF/ID to NOP.
- ID_EX_Bubble  output  1  force ID/EX control fields to zero.
- Mul_Start  output  1  one-cycle registered multiplier start pulse.
- Mul_Busy  output  1  multiplier sequence in progress.
- HiLo_Write  output  1  one-cycle registered HI/LO accumulate-write pulse.
- StallCycles  output  32  stall cycle count (see Optional Feature).

Behaviour:
- States: RUN, MUL_WAIT. Reset: state=RUN, counter=0, Mul_Start=0, HiLo_Write=0, StallCycles=0.
- Reset asserted mid-MUL_WAIT aborts the sequence to RUN with no HiLo_Write pulse.
- Combinational outputs during reset: PCWrite=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Bubble=0.
- UsesRt decode: opcode 0 (R), 28 (MADDU), 43 (SW), 4 (BEQ) read rt. Opcodes 9 (ADDIU), 35 (LW), 2 (J) and all others do not.
- LoadUse = EX_MemRead & (EX_Rt!=0) & ((EX_Rt==ID_Rs) | (UsesRt & EX_Rt==ID_Rt)).
- RUN priority, evaluated combinationally each cycle:
  1. EX_BranchTaken: IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=1. No MADDU start. Stay in RUN.
  2. LoadUse: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1. Lasts one cycle; the LW then leaves EX.
  3. ID_Opcode==28: at the clock edge, Mul_Start<=1, counter<=MUL_LATENCY-1, state<=MUL_WAIT. The MADDU itself advances normally this cycle.
  4. ID_Opcode==2: IF_ID_Flush=1. PC and IF/ID are written.
  5. Otherwise: PCWrite=1, IF_ID_Write=1, others 0.
- MUL_WAIT:
  - PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, Mul_Busy=1.
  - Mul_Start is high only in the first MUL_WAIT cycle.
  - Counter decrements each cycle. At counter==0: HiLo_Write<=1 on the next edge, and state<=RUN on the same edge.
  - EX_BranchTaken in MUL_WAIT cannot occur, because the MADDU was issued after the branch left EX. If asserted anyway, it is ignored.
- MUL_LATENCY=1: MUL_WAIT lasts exactly one cycle. HiLo_Write is high in the first RUN cycle.
- Mul_Busy=1 exactly when state==MUL_WAIT.
- Back-to-back MADDU: the second MADDU is held in ID during MUL_WAIT and starts in the first RUN cycle.
  - HiLo_Write of the first sequence and Mul_Start of the second may then be high in the same cycle; both are legal.

Optional Feature:
- Macro: HAZARD_STALL_COUNT_EN.
- Defined: StallCycles is a 32-bit counter that increments on every cycle with PCWrite==0, saturates at 0xFFFFFFFF, and clears on reset.
- Undefined: StallCycles is tied to 0 and no counter logic is synthesized.

Test Plan:
- Reset: hold rst_n=0 mid-stream -> Mul_Start=0, HiLo_Write=0, Mul_Busy=0, PCWrite=1. After release, state is RUN.
- Load-use: EX_MemRead=1, EX_Rt=8; ID opcode 0, ID_Rt=8 -> one cycle of PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1. Same with ID opcode 9, ID_Rt=8, ID_Rs=3 -> no stall. EX_Rt=0 -> no stall.
- Branch/jump: EX_BranchTaken=1 with ID opcode 28 -> IF_ID_Flush=1, ID_EX_Bubble=1, Mul_Start never asserted. ID opcode 2 alone -> IF_ID_Flush=1 for one cycle, PCWrite=1.
- MADDU, MUL_LATENCY=4: ID opcode 28 at cycle T -> Mul_Start=1 at T+1; Mul_Busy=1 for T+1..T+4; HiLo_Write=1 at T+5; PCWrite=0 for T+1..T+4.
- Abort: assert rst_n=0 at T+2 of a MADDU sequence -> Mul_Busy=0 immediately, no HiLo_Write pulse.
- With HAZARD_STALL_COUNT_EN: the load-use case plus one 4-cycle MADDU -> StallCycles=5. Without the macro -> StallCycles=0.

Source files
------------

// File: rtl/hazard_sequencer.sv
// ID-stage hazard and MADDU sequencing controller: load-use stalls, branch/jump flushes, multiplier busy window.
// Optional stall-cycle counter enabled by defining HAZARD_STALL_COUNT_EN.
module hazard_sequencer #(
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  ID_Opcode,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_Rt,
  input  logic        EX_BranchTaken,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Bubble,
  output logic        Mul_Start,
  output logic        Mul_Busy,
  output logic        HiLo_Write,
  output logic [31:0] StallCycles
);

  typedef enum logic [0:0] {RUN = 1'b0, MUL_WAIT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             mul_start_r, hilo_write_r;
  logic             uses_rt_s, load_use_s, maddu_start_s, mul_done_s;

  // Decode which opcodes read rt as a source operand
  always_comb begin
    uses_rt_s = 1'b0;
    case (ID_Opcode)
      6'd0, 6'd28, 6'd43, 6'd4: uses_rt_s = 1'b1;
      default:                  uses_rt_s = 1'b0;
    endcase
  end

  assign load_use_s = EX_MemRead & (EX_Rt != 5'd0) &
                      ((EX_Rt == ID_Rs) | (uses_rt_s & (EX_Rt == ID_Rt)));
  // A MADDU starts only when nothing of higher priority claims the cycle
  assign maddu_start_s = (state_r == RUN) & ~EX_BranchTaken & ~load_use_s & (ID_Opcode == 6'd28);
  assign mul_done_s    = (state_r == MUL_WAIT) & (cnt_r == CNT_ZERO);

  // State and countdown register, plus registered start/writeback pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= RUN;
      cnt_r        <= CNT_ZERO;
      mul_start_r  <= 1'b0;
      hilo_write_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      mul_start_r  <= maddu_start_s;
      hilo_write_r <= mul_done_s;
    end
  end

  // Next-state and countdown logic
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      RUN: begin
        if (maddu_start_s) begin
          state_nxt_s = MUL_WAIT;
          cnt_nxt_s   = CNT_LOAD;
        end else begin
          state_nxt_s = RUN;
          cnt_nxt_s   = cnt_r;
        end
      end
      MUL_WAIT: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = RUN;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = MUL_WAIT;
          cnt_nxt_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_nxt_s = RUN;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Pipeline control outputs; reset forces the free-running defaults
  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    Mul_Busy     = 1'b0;
    if (!rst_n) begin
      PCWrite      = 1'b1;
      IF_ID_Write  = 1'b1;
    end else begin
      case (state_r)
        RUN: begin
          if (EX_BranchTaken) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
          end else if (load_use_s) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
          end else if (ID_Opcode == 6'd2) begin
            IF_ID_Flush  = 1'b1;
          end else begin
            PCWrite      = 1'b1;
            IF_ID_Write  = 1'b1;
          end
        end
        MUL_WAIT: begin
          PCWrite      = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_Bubble = 1'b1;
          Mul_Busy     = 1'b1;
        end
        default: begin
          PCWrite      = 1'b1;
          IF_ID_Write  = 1'b1;
        end
      endcase
    end
  end

  assign Mul_Start  = mul_start_r;
  assign HiLo_Write = hilo_write_r;

`ifdef HAZARD_STALL_COUNT_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of cycles in which the PC was held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 32'd0;
    end else if (!PCWrite && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign StallCycles = stall_cnt_r;
`else
  assign StallCycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer (MUL_LATENCY=4): reset, load-use, branch/jump, MADDU timing, abort.
module tb_hazard_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        ex_memread, ex_branchtaken;
  logic        pcwrite, if_id_write, if_id_flush, id_ex_bubble;
  logic        mul_start, mul_busy, hilo_write;
  logic [31:0] stallcycles;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

`ifdef HAZARD_STALL_COUNT_EN
  localparam logic [31:0] EXP_STALL = 32'd5;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
`endif

  hazard_sequencer #(.MUL_LATENCY(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_Opcode(id_opcode), .ID_Rs(id_rs), .ID_Rt(id_rt),
    .EX_MemRead(ex_memread), .EX_Rt(ex_rt), .EX_BranchTaken(ex_branchtaken),
    .PCWrite(pcwrite), .IF_ID_Write(if_id_write), .IF_ID_Flush(if_id_flush),
    .ID_EX_Bubble(id_ex_bubble), .Mul_Start(mul_start), .Mul_Busy(mul_busy),
    .HiLo_Write(hilo_write), .StallCycles(stallcycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pipeline-control snapshot: PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble
  task automatic chk_ctl(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, pcwrite, if_id_write, if_id_flush, id_ex_bubble}, {28'd0, exp});
  endtask

  // Multiplier snapshot: Mul_Start, Mul_Busy, HiLo_Write
  task automatic chk_mul(input string tag, input logic [2:0] exp);
    chk(tag, {29'd0, mul_start, mul_busy, hilo_write}, {29'd0, exp});
  endtask

  task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic mr, input logic [4:0] ert, input logic br);
    id_opcode = op; id_rs = rs; id_rt = rt;
    ex_memread = mr; ex_rt = ert; ex_branchtaken = br;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(6'd0, 5'd0, 5'd8, 1'b1, 5'd8, 1'b0);
    #3;
    chk_ctl("reset_ctl", 4'b1100);
    chk_mul("reset_mul", 3'b000);
    chk("reset_stall", stallcycles, 32'd0);

    next_cycle();
    rst_n = 1'b1;
    drive(6'd9, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    chk_ctl("post_reset_ctl", 4'b1100);
    chk_mul("post_reset_mul", 3'b000);

    next_cycle();
    drive(6'd0, 5'd3, 5'd8, 1'b1, 5'd8, 1'b0);
    #1;
    chk_ctl("loaduse_rtype", 4'b0001);

    next_cycle();
    drive(6'd9, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    chk_ctl("loaduse_release", 4'b1100);

    next_cycle();
    drive(6'd9, 5'd3, 5'd8, 1'b1, 5'd8, 1'b0);
    #1;
    chk_ctl("addiu_rt_nostall", 4'b1100);

    next_cycle();
    drive(6'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
    #1;
    chk_ctl("exrt_zero_nostall", 4'b1100);

    next_cycle();
    drive(6'd28, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1);
    #1;
    chk_ctl("branch_flush", 4'b1111);

    next_cycle();
    drive(6'd9, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    chk_mul("branch_no_start", 3'b000);

    next_cycle();
    drive(6'd2, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    chk_ctl("jump_flush", 4'b1110);

    next_cycle();
    drive(6'd9, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    chk_ctl("jump_flush_once", 4'b1100);

    // MADDU issued at T; held in ID afterwards so a second one follows
    next_cycle();
    drive(6'd28, 5'd4, 5'd5, 1'b0, 5'd0, 1'b0);
    #1;
    chk_ctl("maddu_T_ctl", 4'b1100);
    chk_mul("maddu_T_mul", 3'b000);

    next_cycle();
    chk_mul("maddu_T1_mul", 3'b110);
    chk_ctl("maddu_T1_ctl", 4'b0001);

    next_cycle();
    chk_mul("maddu_T2_mul", 3'b010);

    next_cycle();
    ex_branchtaken = 1'b1;
    #1;
    chk_ctl("maddu_T3_branch_ignored", 4'b0001);
    chk_mul("maddu_T3_mul", 3'b010);

    next_cycle();
    ex_branchtaken = 1'b0;
    #1;
    chk_mul("maddu_T4_mul", 3'b010);
    chk_ctl("maddu_T4_ctl", 4'b0001);

    next_cycle();
    chk_mul("maddu_T5_hilo", 3'b001);
    chk_ctl("maddu_T5_ctl", 4'b1100);
    chk("stall_count", stallcycles, EXP_STALL);

    next_cycle();
    drive(6'd9, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    chk_mul("b2b_second_start", 3'b110);

    next_cycle();
    rst_n = 1'b0;
    #1;
    chk_mul("abort_mul", 3'b000);
    chk_ctl("abort_ctl", 4'b1100);

    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      chk_mul("abort_no_hilo", 3'b000);
    end
    chk("abort_stall_clear", stallcycles, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
